// File: rtl/moore_seq_counter.sv
// moore_seq_counter: four-state Moore sequencer (IDLE/ARM/RUN/HOLD) with a
// parametrised event counter, wrap/saturate mode, sticky match flag,
// per-state output code and registered enter/leave-IDLE strobes.
module moore_seq_counter #(
   parameter int unsigned CNT_W     = 5,
   parameter int unsigned MATCH_VAL = 20,
   parameter int unsigned LIMIT_VAL = 23,
   parameter int unsigned WRAP_VAL  = 24,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned OUT_W     = 3
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic             s1,
   input  logic             s2,
   input  logic             clr,
   output logic [CNT_W-1:0] counter,
   output logic [1:0]       state,
   output logic [OUT_W-1:0] state_code,
   output logic             match_flag,
   output logic             enter_idle,
   output logic             leave_idle
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] MATCH_C = CNT_W'(MATCH_VAL);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT_VAL);
   localparam logic [CNT_W-1:0] WRAP_C  = CNT_W'(WRAP_VAL);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] counter_d;
   logic             match_d;
   logic             enter_d;
   logic             leave_d;
   logic             inc;

   // Next state, counter, match flag and strobes from the current registered state
   always_comb begin
      state_d   = state_q;
      counter_d = counter;
      match_d   = match_flag;
      enter_d   = 1'b0;
      leave_d   = 1'b0;
      inc       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            inc = s2;
            if (start) begin
               state_d = s1 ? ST_ARM : ST_RUN;
            end
         end
         ST_ARM: begin
            inc     = s2;
            state_d = s1 ? ST_RUN : ST_IDLE;
         end
         ST_RUN: begin
            inc     = s2;
            state_d = s1 ? ST_IDLE : ST_HOLD;
         end
         ST_HOLD: begin
            inc = s1;
            if (!s1 || (counter == LIMIT_C)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter priority: clear, wrap/saturate, increment, idle clean-up
      if (clr) begin
         counter_d = '0;
      end else if (inc && (counter == WRAP_C)) begin
         counter_d = (SATURATE != 0) ? WRAP_C : '0;
      end else if (inc) begin
         counter_d = counter + ONE_C;
      end else if ((state_q == ST_IDLE) && (counter == WRAP_C)) begin
         counter_d = '0;
      end

      // Sticky match, clear has priority over a coincident set
      if (clr) begin
         match_d = 1'b0;
      end else if ((state_q == ST_RUN) && (counter == MATCH_C)) begin
         match_d = 1'b1;
      end

      enter_d = (state_d == ST_IDLE) && (state_q != ST_IDLE);
      leave_d = (state_d != ST_IDLE) && (state_q == ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         counter    <= '0;
         match_flag <= 1'b0;
         enter_idle <= 1'b0;
         leave_idle <= 1'b0;
      end else begin
         state_q    <= state_d;
         counter    <= counter_d;
         match_flag <= match_d;
         enter_idle <= enter_d;
         leave_idle <= leave_d;
      end
   end

   assign state = state_q;

   // Moore output code decoded from the registered state only
   always_comb begin
      state_code = '0;
      case (state_q)
         ST_IDLE: state_code = OUT_W'(0);
         ST_ARM:  state_code = OUT_W'(1);
         ST_RUN:  state_code = OUT_W'(2);
         ST_HOLD: state_code = OUT_W'(4);
         default: state_code = '0;
      endcase
   end

endmodule

// File: tb/tb_moore_seq_counter.sv
// Directed testbench for moore_seq_counter; a second instance runs in
// saturate mode on the same stimulus.
module tb_moore_seq_counter;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;
   logic       start   = 1'b0;
   logic       s1      = 1'b0;
   logic       s2      = 1'b0;
   logic       clr     = 1'b0;

   logic [4:0] counter;
   logic [1:0] state;
   logic [2:0] state_code;
   logic       match_flag;
   logic       enter_idle;
   logic       leave_idle;

   logic [4:0] sat_counter;
   logic [1:0] sat_state;
   logic [2:0] sat_state_code;
   logic       sat_match_flag;
   logic       sat_enter_idle;
   logic       sat_leave_idle;

   int checks   = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   moore_seq_counter #(
      .CNT_W(5), .MATCH_VAL(20), .LIMIT_VAL(23), .WRAP_VAL(24), .SATURATE(0), .OUT_W(3)
   ) u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .s1(s1), .s2(s2), .clr(clr),
      .counter(counter), .state(state), .state_code(state_code),
      .match_flag(match_flag), .enter_idle(enter_idle), .leave_idle(leave_idle)
   );

   moore_seq_counter #(
      .CNT_W(5), .MATCH_VAL(20), .LIMIT_VAL(23), .WRAP_VAL(24), .SATURATE(1), .OUT_W(3)
   ) u_dut_sat (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .s1(s1), .s2(s2), .clr(clr),
      .counter(sat_counter), .state(sat_state), .state_code(sat_state_code),
      .match_flag(sat_match_flag), .enter_idle(sat_enter_idle), .leave_idle(sat_leave_idle)
   );

   // Advance one clock and settle away from the edge
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1; start = 1'b0; s1 = 1'b0; s2 = 1'b0; clr = 1'b0;
      step();
      sys_rst = 1'b0;
   endtask

   // Load the counter in IDLE by pulsing s2 n times
   task automatic preload(input int n);
      start = 1'b0; s1 = 1'b0; s2 = 1'b1; clr = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if (counter !== 5'd0) begin failures++; $display("FAIL reset_counter got=%0d exp=0", counter); end
      checks++; if (state_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", state_code); end
      checks++; if ({match_flag, enter_idle, leave_idle} !== 3'b000) begin
         failures++; $display("FAIL reset_flags got=%b exp=000", {match_flag, enter_idle, leave_idle}); end
      start = 1'b0; s1 = 1'b1; s2 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++; if (state !== 2'd0 || state_code !== 3'd0) begin
            failures++; $display("FAIL idle_stay cyc=%0d state=%0d code=%0d exp=0/0", i, state, state_code); end
         checks++; if (enter_idle !== 1'b0 || leave_idle !== 1'b0) begin
            failures++; $display("FAIL idle_nostrobe cyc=%0d got=%b%b exp=00", i, enter_idle, leave_idle); end
      end
      checks++; if (counter !== 5'd5) begin failures++; $display("FAIL idle_count got=%0d exp=5", counter); end
   endtask

   task automatic test_arm_strobes();
      do_reset();
      start = 1'b1; s1 = 1'b1; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd1 || state_code !== 3'd1) begin
         failures++; $display("FAIL arm_enter state=%0d code=%0d exp=1/1", state, state_code); end
      checks++; if (leave_idle !== 1'b1 || enter_idle !== 1'b0) begin
         failures++; $display("FAIL arm_leave_strobe got=%b%b exp=01", enter_idle, leave_idle); end
      start = 1'b0; s1 = 1'b0;
      step();
      checks++; if (state !== 2'd0 || state_code !== 3'd0) begin
         failures++; $display("FAIL arm_exit state=%0d code=%0d exp=0/0", state, state_code); end
      checks++; if (enter_idle !== 1'b1 || leave_idle !== 1'b0) begin
         failures++; $display("FAIL arm_enter_strobe got=%b%b exp=10", enter_idle, leave_idle); end
      step();
      checks++; if (enter_idle !== 1'b0 || leave_idle !== 1'b0) begin
         failures++; $display("FAIL strobe_one_cycle got=%b%b exp=00", enter_idle, leave_idle); end
      // ARM -> RUN keeps both strobes low
      start = 1'b1; s1 = 1'b1;
      step();
      start = 1'b0;
      step();
      checks++; if (state !== 2'd2 || state_code !== 3'd2) begin
         failures++; $display("FAIL arm_to_run state=%0d code=%0d exp=2/2", state, state_code); end
      checks++; if (enter_idle !== 1'b0 || leave_idle !== 1'b0) begin
         failures++; $display("FAIL arm_to_run_strobe got=%b%b exp=00", enter_idle, leave_idle); end
   endtask

   task automatic test_match_clear();
      do_reset();
      preload(19);
      checks++; if (counter !== 5'd19) begin failures++; $display("FAIL preload got=%0d exp=19", counter); end
      start = 1'b1; s1 = 1'b0; s2 = 1'b1;
      step();
      checks++; if (state !== 2'd2 || counter !== 5'd20 || match_flag !== 1'b0) begin
         failures++; $display("FAIL run_entry state=%0d cnt=%0d match=%b exp=2/20/0", state, counter, match_flag); end
      start = 1'b0;
      step();
      checks++; if (state !== 2'd3 || counter !== 5'd21 || state_code !== 3'd4) begin
         failures++; $display("FAIL hold_entry state=%0d cnt=%0d code=%0d exp=3/21/4", state, counter, state_code); end
      checks++; if (match_flag !== 1'b1) begin failures++; $display("FAIL match_set got=%b exp=1", match_flag); end
      s1 = 1'b0; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd0 || counter !== 5'd21 || match_flag !== 1'b1 || enter_idle !== 1'b1) begin
         failures++; $display("FAIL match_sticky state=%0d cnt=%0d match=%b enter=%b exp=0/21/1/1",
                              state, counter, match_flag, enter_idle); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      checks++; if (counter !== 5'd0 || match_flag !== 1'b0) begin
         failures++; $display("FAIL clr cnt=%0d match=%b exp=0/0", counter, match_flag); end
   endtask

   task automatic test_hold_limit();
      do_reset();
      preload(19);
      start = 1'b1; s1 = 1'b0; s2 = 1'b1;
      step();
      start = 1'b0;
      step();
      s1 = 1'b1; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd3 || counter !== 5'd22) begin
         failures++; $display("FAIL hold_inc1 state=%0d cnt=%0d exp=3/22", state, counter); end
      step();
      checks++; if (state !== 2'd3 || counter !== 5'd23) begin
         failures++; $display("FAIL hold_inc2 state=%0d cnt=%0d exp=3/23", state, counter); end
      step();
      checks++; if (state !== 2'd0 || counter !== 5'd24 || enter_idle !== 1'b1) begin
         failures++; $display("FAIL hold_limit state=%0d cnt=%0d enter=%b exp=0/24/1", state, counter, enter_idle); end
      checks++; if (sat_counter !== 5'd24 || sat_state !== 2'd0) begin
         failures++; $display("FAIL sat_hold_limit state=%0d cnt=%0d exp=0/24", sat_state, sat_counter); end
      s1 = 1'b0; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd0 || counter !== 5'd0 || enter_idle !== 1'b0) begin
         failures++; $display("FAIL idle_wrap state=%0d cnt=%0d enter=%b exp=0/0/0", state, counter, enter_idle); end
      checks++; if (match_flag !== 1'b1) begin failures++; $display("FAIL hold_match got=%b exp=1", match_flag); end
   endtask

   task automatic test_wrap_saturate();
      int exp_wrap;
      int exp_sat;
      do_reset();
      start = 1'b0; s1 = 1'b0; s2 = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         step();
         exp_wrap = i % 25;
         exp_sat  = (i < 24) ? i : 24;
         checks++; if (counter !== 5'(exp_wrap)) begin
            failures++; $display("FAIL wrap_seq cyc=%0d got=%0d exp=%0d", i, counter, exp_wrap); end
         checks++; if (sat_counter !== 5'(exp_sat)) begin
            failures++; $display("FAIL sat_seq cyc=%0d got=%0d exp=%0d", i, sat_counter, exp_sat); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      start = 1'b1; s1 = 1'b0; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd2 || leave_idle !== 1'b1) begin
         failures++; $display("FAIL b2b_run state=%0d leave=%b exp=2/1", state, leave_idle); end
      start = 1'b0; s1 = 1'b1;
      step();
      checks++; if (state !== 2'd0 || enter_idle !== 1'b1 || leave_idle !== 1'b0) begin
         failures++; $display("FAIL b2b_idle state=%0d strobes=%b%b exp=0/10", state, enter_idle, leave_idle); end
   endtask

   task automatic test_reset_priority();
      do_reset();
      preload(19);
      start = 1'b1; s1 = 1'b0; s2 = 1'b1;
      step();
      start = 1'b0;
      step();
      s1 = 1'b1; s2 = 1'b0;
      step();
      checks++; if (state !== 2'd3 || counter !== 5'd22 || match_flag !== 1'b1) begin
         failures++; $display("FAIL rst_setup state=%0d cnt=%0d match=%b exp=3/22/1", state, counter, match_flag); end
      sys_rst = 1'b1; clr = 1'b1; s1 = 1'b1;
      step();
      checks++; if (state !== 2'd0 || counter !== 5'd0 || match_flag !== 1'b0) begin
         failures++; $display("FAIL rst_abort state=%0d cnt=%0d match=%b exp=0/0/0", state, counter, match_flag); end
      checks++; if (enter_idle !== 1'b0 || leave_idle !== 1'b0) begin
         failures++; $display("FAIL rst_nostrobe got=%b%b exp=00", enter_idle, leave_idle); end
      sys_rst = 1'b0; clr = 1'b0; s1 = 1'b0;
      step();
      checks++; if (state !== 2'd0 || enter_idle !== 1'b0) begin
         failures++; $display("FAIL rst_after state=%0d enter=%b exp=0/0", state, enter_idle); end
   endtask

   initial begin
      test_reset();
      test_arm_strobes();
      test_match_clear();
      test_hold_limit();
      test_wrap_saturate();
      test_back_to_back();
      test_reset_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
